// File: rtl/reset_seq.sv
// rtl/reset_seq.sv - staged reset sequencer with software-reset responder
//
// Purpose:
//   Takes the debounced system reset and releases the CPU system in stages:
//   peripherals first, then memories, then the CPU core. All stages stay
//   asserted for HOLD_CYCLES stable-clock cycles after the reset cause clears.
//   A 4-phase req/ack responder lets the CPU request a full system reset.
//
// Ports:
//   clk         system clock
//   reset       synchronous active-high system reset (highest priority)
//   clk_ready   divided clock is stable (level, synchronous to clk)
//   sw_rst_req  software reset request from the CPU
//   sw_rst_ack  software reset acknowledge
//   rst_periph  reset to peripherals/IO, active-high
//   rst_mem     reset to instruction/data memories, active-high
//   rst_cpu     reset to pipeline core, active-high
//   sys_ready   all stages released

module reset_seq #(
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_ready,
  input  logic sw_rst_req,
  output logic sw_rst_ack,
  output logic rst_periph,
  output logic rst_mem,
  output logic rst_cpu,
  output logic sys_ready
);

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_REL_P = 3'd1,
    S_REL_M = 3'd2,
    S_RUN   = 3'd3,
    S_SWACK = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Output pattern {ack, periph, mem, cpu, ready} for a given state. Outputs
  // are registered from the next state so they change on the same edge as
  // the state register and never see an input combinationally.
  function automatic logic [4:0] decode(input state_t s);
    case (s)
      S_REL_P: decode = 5'b0_011_0;
      S_REL_M: decode = 5'b0_001_0;
      S_RUN:   decode = 5'b0_000_1;
      S_SWACK: decode = 5'b1_111_0;
      default: decode = 5'b0_111_0;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_HOLD: begin
        if (!clk_ready) begin
          cnt_nxt = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = S_REL_P;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_REL_P, S_REL_M: begin
        if (!clk_ready) begin
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
        end else if (cnt == GAP_LAST) begin
          state_nxt = (state == S_REL_P) ? S_REL_M : S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_RUN: begin
        // Losing the clock outranks a software request: no ack is given.
        if (!clk_ready) begin
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
        end else if (sw_rst_req) begin
          state_nxt = S_SWACK;
          cnt_nxt   = '0;
        end
      end
      S_SWACK: begin
        // clk_ready is deliberately ignored here; the handshake must close.
        if (!sw_rst_req) begin
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_HOLD;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_HOLD;
      cnt        <= '0;
      sw_rst_ack <= 1'b0;
      rst_periph <= 1'b1;
      rst_mem    <= 1'b1;
      rst_cpu    <= 1'b1;
      sys_ready  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      {sw_rst_ack, rst_periph, rst_mem, rst_cpu, sys_ready} <= decode(state_nxt);
    end
  end

endmodule

// File: doc/reset_seq.md
Name: reset_seq

Overview:
- Consumes the debounced, synchronous, active-high system reset and drives staged resets into the pipeline CPU system: peripherals/clock-division consumers first, then memories, then the CPU core.
- Enforces a minimum assertion time and waits for the clock-division unit to report a stable clock before releasing anything.
- Provides a software-reset responder so the CPU core can request a full system reset through a 4-phase req/ack handshake.

Parameters:
HOLD_CYCLES, 16, minimum cycles all resets stay asserted after the reset cause clears (>=1)
GAP_CYCLES, 4, cycles between successive release stages (>=1)
CNT_W, 8, counter width; must hold max(HOLD_CYCLES, GAP_CYCLES)

Ports:
clk  input  1  system clock
reset  input  1  debounced system reset, synchronous, active-high
clk_ready  input  1  clock-division unit reports stable divided clock; level, synchronous to clk
sw_rst_req  input  1  software reset request from CPU; 4-phase handshake
sw_rst_ack  output  1  software reset acknowledge
rst_periph  output  1  reset to peripherals/IO, active-high
rst_mem  output  1  reset to instruction/data memories, active-high
rst_cpu  output  1  reset to pipeline core, active-high
sys_ready  output  1  all stages released

Behaviour:
- Interface: one clock; reset is synchronous and active-high, with ports named clk and reset.
- reset takes priority over all other inputs.
  - On any edge where reset=1: state=HOLD, counter=0.
  - Outputs: rst_periph=rst_mem=rst_cpu=1, sys_ready=0, sw_rst_ack=0.
- All outputs are registered and decoded from the state register. No combinational path from any input to any output.
- States: HOLD, REL_P, REL_M, RUN, SWACK.
- HOLD (all resets 1, sys_ready 0):
  - Counter increments on each edge with reset=0 and clk_ready=1.
  - Counter clears to 0 on any edge with clk_ready=0.
  - When counter==HOLD_CYCLES-1 and clk_ready=1: go to REL_P, counter=0.
- REL_P (rst_periph 0, others 1):
  - Counter increments each edge.
  - At GAP_CYCLES-1: go to REL_M, counter=0.
- REL_M (rst_periph 0, rst_mem 0, rst_cpu 1):
  - Same counting rule.
  - At GAP_CYCLES-1: go to RUN.
- RUN: all resets 0, sys_ready=1.
- clk_ready=0 in REL_P, REL_M or RUN: next state HOLD, counter=0. All resets reassert on that edge.
- SWACK (software reset responder):
  - Entry: sw_rst_req=1 sampled in RUN with clk_ready=1 → SWACK.
  - In SWACK: all resets 1, sys_ready 0, sw_rst_ack 1.
  - Stays in SWACK while sw_rst_req=1.
  - When sw_rst_req=0 is sampled: go to HOLD, counter=0; sw_rst_ack falls on that edge.
  - Full hold/release sequence then repeats.
- sw_rst_req is ignored in HOLD, REL_P and REL_M; sw_rst_ack stays 0 there.
- Priority within RUN: clk_ready=0 beats sw_rst_req=1; go to HOLD, no ack.
- If clk_ready drops while in SWACK, remain in SWACK; ack handling is unchanged.
- Release latency: HOLD_CYCLES + 2*GAP_CYCLES edges from the first edge with reset=0 and clk_ready=1 (uninterrupted) until sys_ready=1.
- Release order is guaranteed: rst_periph ≤ rst_mem ≤ rst_cpu at all times (a later stage is never released before an earlier one).
- Reset is idempotent when asserted mid-sequence; any state returns to HOLD.

Test Plan:
- Defaults, reset=1 for 5 cycles, then 0, clk_ready=1 throughout → rst_periph falls at edge 16 after release, rst_mem at edge 20, rst_cpu and sys_ready at edge 24; sw_rst_ack stays 0.
- clk_ready=0 until 30 cycles after reset deassert, then 1 → rst_periph falls exactly 16 edges after clk_ready rises. Pulse clk_ready low 1 cycle at hold count 10 → count restarts from 0.
- In RUN, drop clk_ready for 1 cycle → all resets 1 and sys_ready 0 on the next edge; full 16+4+4 sequence restarts after clk_ready returns.
- In RUN, raise sw_rst_req, hold 7 cycles, lower it:
  - sw_rst_ack=1 and all resets 1 one edge after req is sampled.
  - ack falls one edge after req=0 is sampled.
  - sys_ready returns 24 edges later.
- sw_rst_req=1 during REL_M → ignored, sequence completes. Then in RUN with req still 1 → SWACK entered on the next edge.
- reset=1 asserted during REL_P and during SWACK → next edge: all resets 1, ack 0, state HOLD. Same-edge sw_rst_req=1 with clk_ready=0 in RUN → HOLD, ack stays 0.
